// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the sequential ALU/multiplier.
// Contents:
//   op_t    - operation select encoding (matches switch field SWI[4:3])
//   state_t - control FSM states
//   NBITS_DEFAULT / RBITS_DEFAULT - default operand and result widths
package alu_seq_pkg;

  localparam int NBITS_DEFAULT = 3;
  localparam int RBITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULU = 2'b10,
    OP_MULS = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/alu_seq_mult.sv
// Small sequential ALU driving an LED bank. Add and subtract complete in a
// single cycle; unsigned and signed multiply run as a shift-add over NBITS
// cycles followed by one sign-fix cycle.
// Ports:
//   clk_2   - clock, all state changes on the rising edge
//   rst_n   - asynchronous active-low reset
//   start   - capture a/b/op and begin an operation (IDLE or DONE only)
//   a, b    - NBITS-wide operands
//   op      - operation select (op_t)
//   busy    - high while a multiply is in progress (RUN/FIX)
//   done    - one-cycle pulse in the cycle result has just been updated
//   result  - registered RBITS-wide result
module alu_seq_mult
  import alu_seq_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT,
  parameter int RBITS = RBITS_DEFAULT
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [RBITS-1:0] result
);

  localparam int CW = $clog2(NBITS) + 1;

  // The largest product magnitude (2^NBITS-1)^2 plus a sign bit must fit.
  if (RBITS < 2 * NBITS + 1) begin : g_width_check
    $error("alu_seq_mult: RBITS must be at least 2*NBITS+1");
  end

  state_t           state_q, state_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  op_t              op_q, op_d;
  logic [CW-1:0]    iter_q, iter_d;
  logic [RBITS-1:0] acc_q, acc_d;
  logic [RBITS-1:0] result_q, result_d;

  logic             mul_signed;
  logic             negate;
  logic [NBITS-1:0] mag_a;
  logic [NBITS-1:0] mag_b;
  logic [NBITS-1:0] b_shift;
  logic [RBITS-1:0] addend;
  logic [RBITS-1:0] product_fixed;
  op_t              op_in;

  // A negative NBITS-bit value has a magnitude of at most 2^(NBITS-1),
  // which still fits in NBITS unsigned bits.
  function automatic logic [NBITS-1:0] magnitude(input logic [NBITS-1:0] v,
                                                 input logic             signed_mode);
    if (signed_mode && v[NBITS-1]) begin
      return -v;
    end
    return v;
  endfunction

  assign op_in      = op_t'(op);
  assign mul_signed = (op_q == OP_MULS);
  assign mag_a      = magnitude(a_q, mul_signed);
  assign mag_b      = magnitude(b_q, mul_signed);

  // The iteration counter selects the multiplier bit and the weight of the
  // partial product, so no operand needs to be shifted in place.
  assign b_shift       = mag_b >> iter_q;
  assign addend        = b_shift[0] ? (RBITS'(mag_a) << iter_q) : '0;
  assign negate        = mul_signed && (a_q[NBITS-1] ^ b_q[NBITS-1]);
  assign product_fixed = negate ? (RBITS'(0) - acc_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    iter_d   = iter_q;
    acc_d    = acc_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          op_d   = op_in;
          iter_d = '0;
          acc_d  = '0;
          // Single-cycle ops write result on the capture edge, which is
          // also the edge that enters DONE.
          if (op_in == OP_ADD) begin
            result_d = RBITS'(a) + RBITS'(b);
            state_d  = ST_DONE;
          end else if (op_in == OP_SUB) begin
            result_d = RBITS'(a) - RBITS'(b);
            state_d  = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d  = acc_q + addend;
        iter_d = iter_q + CW'(1);
        if (iter_q == CW'(NBITS - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = product_fixed;
        state_d  = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      iter_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      iter_q   <= iter_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_alu_seq_mult.sv
// Self-checking bench for alu_seq_mult. A cycle-level behavioural model
// (result from plain integer arithmetic, timing as a busy countdown) is
// compared against the DUT every cycle; directed operations additionally
// pin results, latencies and busy lengths to hand-computed values.
module tb_alu_seq_mult;

  localparam int NB = 3;
  localparam int RB = 8;

  logic          clk_2 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] a     = '0;
  logic [NB-1:0] b     = '0;
  logic [1:0]    op    = 2'b00;
  logic          busy;
  logic          done;
  logic [RB-1:0] result;

  int checkCount  = 0;
  int errorCount  = 0;
  bit checkEnable = 1'b0;

  // Model state
  int            mBusyLeft = 0;
  logic          mDone     = 1'b0;
  logic [RB-1:0] mResult   = '0;
  logic [RB-1:0] mPending  = '0;

  alu_seq_mult #(
    .NBITS(NB),
    .RBITS(RB)
  ) dut (
    .clk_2 (clk_2),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk_2 = ~clk_2;

  // Reference result from the arithmetic definition of each operation.
  function automatic logic [RB-1:0] refOp(input int av, input int bv, input int opv);
    int sa;
    int sb;
    int r;
    case (opv)
      0: r = av + bv;
      1: r = av - bv;
      2: r = av * bv;
      default: begin
        sa = (av >= 2 ** (NB - 1)) ? av - 2 ** NB : av;
        sb = (bv >= 2 ** (NB - 1)) ? bv - 2 ** NB : bv;
        r  = sa * sb;
      end
    endcase
    return r[RB-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] aVal, input logic [NB-1:0] bVal,
                               input logic [1:0] opVal, input logic startVal);
    a     = aVal;
    b     = bVal;
    op    = opVal;
    start = startVal;
  endtask

  // Behavioural model: an accepted single-cycle op shows its result at once;
  // a multiply stays busy NB+1 cycles and then shows its result with done.
  always @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      mBusyLeft = 0;
      mDone     = 1'b0;
      mResult   = '0;
    end else if (mBusyLeft > 0) begin
      mDone     = 1'b0;
      mBusyLeft = mBusyLeft - 1;
      if (mBusyLeft == 0) begin
        mResult = mPending;
        mDone   = 1'b1;
      end
    end else begin
      mDone = 1'b0;
      if (start) begin
        if (op < 2'd2) begin
          mResult = refOp(int'(a), int'(b), int'(op));
          mDone   = 1'b1;
        end else begin
          mPending  = refOp(int'(a), int'(b), int'(op));
          mBusyLeft = NB + 1;
        end
      end
    end
  end

  // Compare process, sampling mid-cycle after the falling edge.
  always @(negedge clk_2) begin
    #1;
    if (checkEnable) begin
      checkOutput("cycBusy", busy, (mBusyLeft > 0) ? 1 : 0);
      checkOutput("cycDone", done, mDone);
      checkOutput("cycResult", result, mResult);
    end
  end

  task automatic runOp(input string name, input logic [NB-1:0] aVal,
                       input logic [NB-1:0] bVal, input logic [1:0] opVal,
                       input logic [RB-1:0] expResult, input bit disturb);
    int cycles;
    int busyCycles;
    @(negedge clk_2);
    applyStimulus(aVal, bVal, opVal, 1'b1);
    @(negedge clk_2);
    start      = 1'b0;
    cycles     = 1;
    busyCycles = 0;
    #1;
    while (!done && cycles < 20) begin
      if (busy) begin
        busyCycles++;
        if (disturb) begin
          applyStimulus(NB'($urandom_range(0, 7)), NB'($urandom_range(0, 7)),
                        2'($urandom_range(0, 3)), 1'b1);
        end
      end
      @(negedge clk_2);
      #1;
      cycles++;
    end
    start = 1'b0;
    checkOutput({name, "Latency"}, cycles, (opVal < 2'd2) ? 1 : NB + 2);
    checkOutput({name, "BusyLen"}, busyCycles, (opVal < 2'd2) ? 0 : NB + 1);
    checkOutput({name, "Result"}, result, expResult);
  endtask

  initial begin
    int doneSeen;

    // Pin the reference model to hand-computed values.
    checkOutput("modelAdd", refOp(7, 7, 0), 8'h0E);
    checkOutput("modelSub", refOp(2, 5, 1), 8'hFD);
    checkOutput("modelMulS", refOp(7, 3, 3), 8'hFD);
    checkOutput("modelMulS2", refOp(4, 4, 3), 8'h10);

    // Reset state
    repeat (2) @(negedge clk_2);
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstResult", result, 0);
    @(negedge clk_2);
    rst_n       = 1'b1;
    checkEnable = 1'b1;

    $display("[TB] directed operations");
    runOp("add77", 3'd7, 3'd7, 2'b00, 8'h0E, 1'b0);
    runOp("sub25", 3'd2, 3'd5, 2'b01, 8'hFD, 1'b0);
    runOp("sub52", 3'd5, 3'd2, 2'b01, 8'h03, 1'b0);
    runOp("mulu77", 3'd7, 3'd7, 2'b10, 8'h31, 1'b1);

    // Reset in the second RUN cycle, then a start on the first edge after release.
    @(negedge clk_2);
    applyStimulus(3'd5, 3'd6, 2'b10, 1'b1);
    @(negedge clk_2);
    start = 1'b0;
    @(negedge clk_2);
    rst_n = 1'b0;
    #1;
    checkOutput("midRunBusy", busy, 0);
    checkOutput("midRunResult", result, 0);
    checkOutput("midRunDone", done, 0);
    repeat (2) @(negedge clk_2);
    applyStimulus(3'd2, 3'd3, 2'b00, 1'b1);
    rst_n = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    #1;
    checkOutput("firstStartDone", done, 1);
    checkOutput("firstStartResult", result, 8'h05);
    doneSeen = 0;
    repeat (8) begin
      @(negedge clk_2);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("noStaleDone", doneSeen, 0);

    runOp("muls44", 3'b100, 3'b100, 2'b11, 8'h10, 1'b0);
    runOp("muls73", 3'b111, 3'b011, 2'b11, 8'hFD, 1'b0);
    runOp("muls30", 3'b011, 3'b000, 2'b11, 8'h00, 1'b0);

    // Back-to-back: start held high through DONE re-captures immediately.
    @(negedge clk_2);
    applyStimulus(3'd1, 3'd1, 2'b00, 1'b1);
    @(negedge clk_2);
    #1;
    checkOutput("b2bFirstDone", done, 1);
    checkOutput("b2bFirstResult", result, 8'h02);
    applyStimulus(3'd3, 3'd2, 2'b10, 1'b1);
    @(negedge clk_2);
    start    = 1'b0;
    doneSeen = 0;
    repeat (10) begin
      #1;
      if (done) doneSeen++;
      @(negedge clk_2);
    end
    checkOutput("b2bSecondPulses", doneSeen, 1);
    checkOutput("b2bFinalResult", result, 8'h06);

    $display("[TB] randomized operations");
    repeat (400) begin
      @(negedge clk_2);
      applyStimulus(NB'($urandom_range(0, 7)), NB'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
      rst_n = ($urandom_range(0, 79) != 0);
    end
    @(negedge clk_2);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (10) @(negedge clk_2);
    #2;
    checkEnable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
